// File: rtl/norm_seq.sv
// norm_seq: sequential leading-zero normalizer, CHUNK bits per scan cycle; define NORM_SEQ_BYPASS_EN to skip scanning when the MSB is already set
module norm_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [WIDTH-1:0]           InNum,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [WIDTH-1:0]           OutNum,
  output logic [$clog2(WIDTH+1)-1:0] OutCnt,
  output logic                       OutZero
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int ZW = $clog2(CHUNK);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [CHUNK-1:0] top;
  logic [ZW-1:0] z;
  assign top = OutNum[WIDTH-1 -: CHUNK];
  always_comb begin
    z = '0;
    for (int i = 0; i < CHUNK; i++) if (top[i]) z = ZW'(CHUNK-1-i);
  end
  // OutNum doubles as the work register; InReady is gated so it reads 0 while reset is held
  assign InReady  = reset_n && state == IDLE;
  assign OutValid = state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      OutNum  <= '0;
      OutCnt  <= '0;
      OutZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (InValid) begin
          OutNum  <= InNum;
          OutCnt  <= '0;
          OutZero <= 1'b0;
`ifdef NORM_SEQ_BYPASS_EN
          state   <= InNum[WIDTH-1] ? DONE : SCAN;
`else
          state   <= SCAN;
`endif
        end
        SCAN: if (top != '0) begin
          OutNum <= OutNum << z;
          OutCnt <= OutCnt + CW'(z);
          state  <= DONE;
        end else if (OutCnt == CW'(WIDTH-CHUNK)) begin
          OutCnt  <= CW'(WIDTH);
          OutZero <= 1'b1;
          state   <= DONE;
        end else begin
          OutNum <= OutNum << CHUNK;
          OutCnt <= OutCnt + CW'(CHUNK);
        end
        DONE: if (OutReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_norm_seq.sv
// tb_norm_seq: randomized scoreboard bench for norm_seq (WIDTH=64, CHUNK=16)
module tb_norm_seq;
  localparam int W = 64, C = 16, CW = 7;
  logic clk = 0, reset_n = 0, InValid = 0, OutReady = 1;
  logic [W-1:0] InNum = '0;
  logic InReady, OutValid, OutZero;
  logic [W-1:0] OutNum;
  logic [CW-1:0] OutCnt;

  norm_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady), .InNum(InNum),
    .OutValid(OutValid), .OutReady(OutReady), .OutNum(OutNum), .OutCnt(OutCnt), .OutZero(OutZero)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0, n_acc = 0, n_out = 0, n_sent = 0;
  bit rnd_en = 0;
  typedef struct {
    logic [W-1:0] num;
    logic [CW-1:0] cnt;
    logic zero;
    int acc;
    int lat;
  } exp_t;
  exp_t q[$];

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // reference: count leading zeros directly, derive scan count from it
  function automatic exp_t model(logic [W-1:0] x, int acc);
    exp_t e;
    int lz = 0;
    int k;
    while (lz < W && !x[W-1-lz]) lz++;
    e.num  = x << lz;
    e.cnt  = CW'(lz);
    e.zero = (x == '0);
    e.acc  = acc;
    k = lz / C + 1;
    if (k > W / C) k = W / C;
    e.lat = k + 1;
`ifdef NORM_SEQ_BYPASS_EN
    if (x[W-1]) e.lat = 1;
`endif
    return e;
  endfunction

  always @(negedge clk)
    if (reset_n && InValid && InReady) begin
      q.push_back(model(InNum, cyc));
      n_acc++;
    end

  bit pv = 0;
  always @(negedge clk) begin
    if (!reset_n) pv = 0;
    else begin
      if (OutValid && !pv) begin
        chk("valid_expected", q.size() != 0, 1);
        if (q.size() != 0) chk("latency", cyc - q[0].acc, q[0].lat);
      end
      if (OutValid && OutReady) begin
        chk("out_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("num", OutNum, q[0].num);
          chk("cnt", OutCnt, q[0].cnt);
          chk("zero", OutZero, q[0].zero);
          void'(q.pop_front());
          n_out++;
        end
      end
      pv = OutValid;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_en) OutReady = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [W-1:0] x);
    bit ok = 0;
    InValid = 1;
    InNum = x;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = InReady;
      if (!ok) step();
    end
    chk("accept", ok, 1);
    step();
    n_sent++;
    InValid = 0;
    InNum = {$urandom, $urandom};
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit ok;
    logic [W-1:0] r;
    #3;
    chk("rst_inready", InReady, 0);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_outnum", OutNum, 0);
    chk("rst_outcnt", OutCnt, 0);
    chk("rst_outzero", OutZero, 0);
    repeat (2) step();
    reset_n = 1;
    #1 chk("inready_after_rst", InReady, 1);
    step();
    send(64'h0000_0000_0001_0000);
    send(64'h0);
    send(64'h8000_0000_0000_0001);
    drain();
    send(64'h1);
    send(64'h4000_0000_0000_0000);
    drain();
    // hold results while consumer stalls, with a competing request
    OutReady = 0;
    send(64'h00F0_1234_5678_9ABC);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = OutValid;
    end
    chk("hold_valid_seen", ok, 1);
    step();
    InValid = 1;
    InNum = {$urandom, $urandom};
    repeat (10) begin
      @(negedge clk);
      chk("hold_num", OutNum, 64'hF012_3456_789A_BC00);
      chk("hold_cnt", OutCnt, 8);
      chk("hold_zero", OutZero, 0);
      chk("hold_valid", OutValid, 1);
      chk("hold_inready", InReady, 0);
    end
    step();
    InValid = 0;
    OutReady = 1;
    step();
    chk("idle_after_ready", InReady, 1);
    chk("valid_after_ready", OutValid, 0);
    // reset during second scan cycle discards the operand
    send(64'h0);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("midrst_outvalid", OutValid, 0);
    chk("midrst_inready", InReady, 0);
    chk("midrst_outnum", OutNum, 0);
    chk("midrst_outcnt", OutCnt, 0);
    chk("midrst_outzero", OutZero, 0);
    q.delete();
    step();
    reset_n = 1;
    #1 chk("midrst_inready_release", InReady, 1);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_result", OutValid, 0);
    end
    step();
    rnd_en = 1;
    repeat (300) begin
      r = {$urandom, $urandom};
      send(r >> $urandom_range(0, 64));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
    end
    drain();
    rnd_en = 0;
    OutReady = 1;
    repeat (3) step();
    chk("accept_count", n_acc, n_sent);
    chk("result_count", n_out, n_sent - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/norm_seq.md
NORM_SEQ -- requirements
Module: norm_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width in bits, a multiple of CHUNK, at least 2*CHUNK.
REQ-002 SHALL have parameter CHUNK, default 16: bits examined per scan cycle, a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port InValid  input  1  requester offers an operand.
REQ-006 SHALL have port InReady  output  1  block can accept an operand.
REQ-007 SHALL have port InNum  input  WIDTH  operand to normalize.
REQ-008 SHALL have port OutValid  output  1  result available.
REQ-009 SHALL have port OutReady  input  1  consumer accepts the result.
REQ-010 SHALL have port OutNum  output  WIDTH  operand shifted left by OutCnt.
REQ-011 SHALL have port OutCnt  output  $clog2(WIDTH+1)  number of leading zeros of the accepted operand.
REQ-012 SHALL have port OutZero  output  1  accepted operand was all zeros.

Function
REQ-013 SHALL implement three states: IDLE, SCAN and DONE.
REQ-014 SHALL drive InReady=1 only in IDLE; OutValid=1 only in DONE.
REQ-015 In IDLE, when InValid&InReady, SHALL load the work register with InNum, clear the count, and enter SCAN.
REQ-016 In IDLE without InValid, SHALL remain in IDLE.
REQ-017 SCAN, each cycle, SHALL examine the top CHUNK bits of the work register.
REQ-018 SCAN, top chunk all zero and count+CHUNK<WIDTH: SHALL shift the work register left CHUNK, add CHUNK to count, stay in SCAN.
REQ-019 SCAN, top chunk all zero and count+CHUNK=WIDTH: SHALL set count=WIDTH and OutZero=1, leave the work register zero, enter DONE.
REQ-020 SCAN, top chunk nonzero: SHALL take z = leading-zero count of the chunk (0..CHUNK-1), shift the work register left z, add z to count, enter DONE.
REQ-021 Latency: with k = number of SCAN cycles (k = floor(lzc/CHUNK)+1, at most WIDTH/CHUNK), OutValid SHALL rise k+1 cycles after the accepting edge.
REQ-022 In DONE, OutNum/OutCnt/OutZero SHALL be held stable until OutValid&OutReady.
REQ-023 On DONE with OutReady=1, SHALL return to IDLE; a new operand is accepted no earlier than the following cycle.
REQ-024 InValid and InNum SHALL be ignored outside IDLE.
REQ-025 OutNum SHALL have its MSB set whenever OutZero=0.
REQ-026 All count arithmetic SHALL be unsigned in $clog2(WIDTH+1) bits and SHALL never exceed WIDTH.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, regardless of state, including mid-SCAN or DONE.
REQ-028 reset_n=0 SHALL immediately clear the work register, count and OutZero to 0.
REQ-029 During reset, outputs SHALL be InReady=0, OutValid=0, OutNum=0, OutCnt=0, OutZero=0.
REQ-030 InReady SHALL be 1 in the first cycle after reset_n deasserts.
REQ-031 An in-flight operand SHALL be discarded by reset without producing a result.

Configuration
REQ-032 Macro NORM_SEQ_BYPASS_EN, when defined: if InNum[WIDTH-1]=1 at acceptance, SHALL enter DONE directly with count 0, giving OutValid 1 cycle after the accepting edge.
REQ-033 Macro NORM_SEQ_BYPASS_EN, when undefined: such operands SHALL take one SCAN cycle (z=0), giving OutValid 2 cycles after the accepting edge.
REQ-034 NORM_SEQ_BYPASS_EN SHALL NOT change results, only latency.

Verification (WIDTH=64, CHUNK=16)
REQ-035 Bench SHALL cover: InNum=0x0000_0000_0001_0000 -> 3 SCAN cycles; OutValid 4 cycles after accept; OutCnt=47, OutNum=0x8000_0000_0000_0000, OutZero=0.
REQ-036 Bench SHALL cover: InNum=0 -> 4 SCAN cycles; OutValid at cycle 5; OutCnt=64, OutNum=0, OutZero=1.
REQ-037 Bench SHALL cover: InNum=0x8000_0000_0000_0001 -> OutCnt=0, OutNum unchanged; OutValid at cycle 1 with NORM_SEQ_BYPASS_EN defined, at cycle 2 without.
REQ-038 Bench SHALL cover: InNum=0x00F0_1234_5678_9ABC with OutReady low for 10 cycles -> OutCnt=8, OutNum=0xF012_3456_789A_BC00; outputs stable, InReady=0, a competing InValid ignored; IDLE one cycle after OutReady rises.
REQ-039 Bench SHALL cover: reset_n pulsed low during the second SCAN cycle of operand 0 -> OutValid=0 and all outputs 0 immediately; InReady=1 in the first cycle after release; no result emitted.
REQ-040 Bench SHALL cover: back-to-back operands 0x1 then 0x4000_0000_0000_0000 with OutReady=1 -> OutCnt=63 then 1, results in order, no lost or duplicated handshakes.
